// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : core_ctrl_pkg                                                |
// | Shared bit indices, T-state codes and the strobe decode function used  |
// | by the 8085 machine-cycle sequencer.                                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package core_ctrl_pkg;

  // ienb strobe bit positions
  localparam int IENB_RRD = 0;
  localparam int IENB_RWR = 1;
  localparam int IENB_COD = 2;
  localparam int IENB_DAT = 3;
  localparam int IENB_PC  = 4;
  localparam int IENB_PD  = 5;

  // chk_i decode word field positions
  localparam int INST_GO6 = 0;
  localparam int INST_DAD = 1;
  localparam int INST_HLT = 2;
  localparam int INST_DIO = 3;
  localparam int INST_CYC = 4;
  localparam int INST_RW  = 8;
  localparam int INST_CD  = 12;
  localparam int INST_CCC = 16;

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    TW   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    THLT = 3'd7
  } tstate_t;

  // Latched per-instruction cycle description; bit k describes M(k+2).
  typedef struct packed {
    logic [3:0] cd;   // 1 = data/pair-addressed byte, 0 = code byte
    logic [3:0] rw;   // 1 = write cycle
    logic [3:0] cyc;  // contiguous extra-cycle mask
  } dec_t;

  typedef struct packed {
    logic [5:0] ienb;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic       io_m;
    logic       hlta;
  } bus_t;

  // Strobes to present while sitting in T-state t of machine cycle m.
  function automatic bus_t bus_out(input tstate_t t, input logic [2:0] m,
                                   input dec_t d, input logic dio,
                                   input logic hlt);
    bus_t       b;
    logic [1:0] ix;     // index of the current cycle in the M2..M5 masks
    logic [1:0] nx;     // index of the following cycle
    logic       mn;
    logic       wrc;
    logic       last;
    b    = '{ienb: 6'd0, ale: 1'b0, rd_n: 1'b1, wr_n: 1'b1, io_m: 1'b0, hlta: 1'b0};
    ix   = m[1:0] - 2'd2;
    nx   = m[1:0] - 2'd1;
    mn   = (m != 3'd1);
    wrc  = mn & d.rw[ix];
    last = (m == 3'd5) | ~d.cyc[nx];
    b.io_m = dio & (m == 3'd3);
    case (t)
      T1: begin
        b.ale          = 1'b1;
        b.ienb[IENB_PD] = mn & d.cd[ix];
      end
      T2, TW: begin
        if (wrc) begin
          b.wr_n           = 1'b0;
          b.ienb[IENB_RRD] = 1'b1;
        end else begin
          b.rd_n = 1'b0;
        end
      end
      T3: begin
        if (wrc) begin
          b.wr_n           = 1'b0;
          b.ienb[IENB_RRD] = 1'b1;
        end else begin
          b.rd_n = 1'b0;
          if (!mn) begin
            b.ienb[IENB_COD] = 1'b1;
            b.ienb[IENB_PC]  = 1'b1;
          end else begin
            b.ienb[IENB_DAT] = 1'b1;
            b.ienb[IENB_PC]  = ~d.cd[ix];
            b.ienb[IENB_RWR] = last;
          end
        end
      end
      T4: begin
        if (!hlt && d.cyc == 4'd0) begin
          b.ienb[IENB_RRD] = 1'b1;
          b.ienb[IENB_RWR] = 1'b1;
        end
      end
      T6: begin
        b.ienb[IENB_RRD] = 1'b1;
        b.ienb[IENB_RWR] = 1'b1;
      end
      THLT: begin
        b.hlta = 1'b1;
        b.io_m = 1'b0;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_ctrl_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : core_ctrl_reg                                                |
// | Loadable register with synchronous active-low clear.                   |
// | Ports   : clk, rst_ (sync, active-low), ld (load enable),              |
// |           d (data in), q (data out)                                    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module core_ctrl_reg #(
  parameter int DATASIZE = 12
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                ld,
  input  logic [DATASIZE-1:0] d,
  output logic [DATASIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : core_ctrl                                                    |
// | 8085 machine-cycle / T-state sequencer. Runs the opcode fetch, the     |
// | extra M2..M5 cycles described by the alureg decode word, and drives    |
// | the external bus strobes and the ienb strobes into alureg.             |
// | Ports   : clk, rst_ (sync, active-low), ready (bus ready),             |
// |           chk_i (decode word) -> ienb, ale, rd_, wr_, io_m, hlta,      |
// |           tstate, mcyc (debug)                                         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int IENBSIZE = 6,
  parameter int INSTSIZE = 17,
  parameter int CYCBITS  = 4
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                ready,
  input  logic [INSTSIZE-1:0] chk_i,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                io_m,
  output logic                hlta,
  output logic [2:0]          tstate,
  output logic [2:0]          mcyc
);

  localparam int DECW = 3 * CYCBITS;

  tstate_t           state;
  tstate_t           ns;
  logic [2:0]        nm;
  logic              run;      // low for the one cycle after reset: emit idle strobes
  logic              ld;
  logic              go6_q;
  logic              hlt_q;
  logic              dio_q;
  logic              ndio;
  logic              nhlt;
  logic [DECW-1:0]   dec_d;
  logic [DECW-1:0]   dec_q;
  dec_t              dec;
  dec_t              nd;
  logic [1:0]        nx;
  bus_t              bo;

  // GO6 wants DAD/CCC in a later revision; they are intentionally ignored now.
  logic unused_bits;
  assign unused_bits = ^{chk_i[INST_DAD], chk_i[INST_CCC]};

  assign dec_d  = {chk_i[INST_CD +: CYCBITS], chk_i[INST_RW +: CYCBITS],
                   chk_i[INST_CYC +: CYCBITS]};
  assign dec    = dec_t'(dec_q);
  assign tstate = state;
  assign nx     = mcyc[1:0] - 2'd1;

  core_ctrl_reg #(
    .DATASIZE (DECW)
  ) u_dec (
    .clk  (clk),
    .rst_ (rst_),
    .ld   (ld),
    .d    (dec_d),
    .q    (dec_q)
  );

  // Next state. The decode word is captured on the edge that enters M1 T4,
  // so the T4 strobes (registered) already reflect the new instruction.
  always_comb begin
    ns = state;
    nm = mcyc;
    ld = 1'b0;
    if (!run) begin
      ns = T1;
      nm = 3'd1;
    end else begin
      case (state)
        T1: ns = T2;
        T2, TW: ns = ready ? T3 : TW;
        T3: begin
          ns = T1;
          if (mcyc == 3'd1) begin
            ns = T4;
            ld = 1'b1;
          end else if (mcyc != 3'd5 && dec.cyc[nx]) begin
            nm = mcyc + 3'd1;
          end else begin
            nm = 3'd1;
          end
        end
        T4: begin
          if (hlt_q) begin
            ns = THLT;
          end else if (go6_q) begin
            ns = T5;
          end else begin
            ns = T1;
            if (dec.cyc != 4'd0) nm = 3'd2;
          end
        end
        T5: ns = T6;
        T6: begin
          ns = T1;
          if (dec.cyc != 4'd0) nm = 3'd2;
        end
        THLT: ns = THLT;
        default: begin
          ns = T1;
          nm = 3'd1;
        end
      endcase
    end
    nd   = ld ? dec_t'(dec_d) : dec;
    ndio = ld ? chk_i[INST_DIO] : dio_q;
    nhlt = ld ? chk_i[INST_HLT] : hlt_q;
    bo   = bus_out(ns, nm, nd, ndio, nhlt);
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= T1;
      mcyc  <= 3'd1;
      run   <= 1'b0;
      go6_q <= 1'b0;
      hlt_q <= 1'b0;
      dio_q <= 1'b0;
      ienb  <= '0;
      ale   <= 1'b0;
      rd_   <= 1'b1;
      wr_   <= 1'b1;
      io_m  <= 1'b0;
      hlta  <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= ns;
      mcyc  <= nm;
      if (ld) begin
        go6_q <= chk_i[INST_GO6];
        hlt_q <= chk_i[INST_HLT];
        dio_q <= chk_i[INST_DIO];
      end
      ienb <= bo.ienb;
      ale  <= bo.ale;
      rd_  <= bo.rd_n;
      wr_  <= bo.wr_n;
      io_m <= bo.io_m;
      hlta <= bo.hlta;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_core_ctrl                                                 |
// | Self-checking bench for core_ctrl. Each instruction is expanded into   |
// | its expected per-clock bus sequence from the machine-cycle rules, and  |
// | the bench plays the alureg/bus side cycle by cycle.                    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_core_ctrl;

  localparam int C_T1 = 0, C_T2 = 1, C_TW = 2, C_T3 = 3, C_T4 = 4, C_T5 = 5, C_T6 = 6, C_THLT = 7;
  localparam logic [5:0] RRD = 6'b000001, RWR = 6'b000010, COD = 6'b000100,
                         DAT = 6'b001000, PCE = 6'b010000, PDE = 6'b100000;

  typedef struct packed {
    logic [2:0]  t;
    logic [2:0]  m;
    logic [5:0]  ienb;
    logic        ale;
    logic        rdn;
    logic        wrn;
    logic        io;
    logic        hl;
    logic        rdy;
    logic [16:0] chk;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        ready = 1'b1;
  logic [16:0] chk_i = '0;
  logic [5:0]  ienb;
  logic        ale, rd_, wr_, io_m, hlta;
  logic [2:0]  tstate, mcyc;

  int   n_cmp = 0;
  int   n_err = 0;
  rec_t exp_q[$];

  core_ctrl dut (
    .clk    (clk),
    .rst_   (rst_),
    .ready  (ready),
    .chk_i  (chk_i),
    .ienb   (ienb),
    .ale    (ale),
    .rd_    (rd_),
    .wr_    (wr_),
    .io_m   (io_m),
    .hlta   (hlta),
    .tstate (tstate),
    .mcyc   (mcyc)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mkw(input logic [3:0] cyc, input logic [3:0] rw,
                                      input logic [3:0] cd, input logic go6,
                                      input logic hlt, input logic dio);
    return {1'b0, cd, rw, cyc, dio, hlt, 1'b0, go6};
  endfunction

  task automatic add(input int t, input int m, input logic [5:0] ie, input logic a,
                     input logic rdn, input logic wrn, input logic io, input logic hl,
                     input logic rdy, input logic [16:0] c);
    rec_t r;
    r.t = 3'(t); r.m = 3'(m); r.ienb = ie; r.ale = a; r.rdn = rdn; r.wrn = wrn;
    r.io = io; r.hl = hl; r.rdy = rdy; r.chk = c;
    exp_q.push_back(r);
  endtask

  // Expand one instruction into expected clocks. wt holds 2 bits of wait
  // states per machine cycle (M1 in bits 1:0).
  task automatic model_instr(input logic [16:0] w, input logic [9:0] wt, input int halt_n);
    logic [3:0] cyc, rw, cd;
    int         n, nw;
    logic       wr, cdb, io;
    logic [16:0] c;
    cyc = w[7:4]; rw = w[11:8]; cd = w[15:12];
    n = 0;
    for (int i = 0; i < 4; i++) if (cyc[i]) n++;
    for (int k = 1; k <= n + 1; k++) begin
      wr  = (k > 1) && rw[k-2];
      cdb = (k > 1) && cd[k-2];
      io  = w[3] && (k == 3);
      nw  = int'(wt[2*(k-1) +: 2]);
      c   = (k == 1) ? w : 17'($urandom);
      add(C_T1, k, cdb ? PDE : 6'd0, 1, 1, 1, io, 0, 1'($urandom), c);
      for (int j = 0; j <= nw; j++)
        add(j == 0 ? C_T2 : C_TW, k, wr ? RRD : 6'd0, 0, wr, !wr, io, 0, j == nw, c);
      if (k == 1)
        add(C_T3, 1, COD | PCE, 0, 0, 1, 0, 0, 1'($urandom), w);
      else if (wr)
        add(C_T3, k, RRD, 0, 1, 0, io, 0, 1'($urandom), c);
      else
        add(C_T3, k, DAT | (cdb ? 6'd0 : PCE) | (k == n + 1 ? RWR : 6'd0), 0, 0, 1, io, 0,
            1'($urandom), c);
      if (k == 1) begin
        add(C_T4, 1, (w[2] || n != 0) ? 6'd0 : (RRD | RWR), 0, 1, 1, 0, 0, 1'($urandom),
            17'($urandom));
        if (w[2]) begin
          for (int h = 0; h < halt_n; h++)
            add(C_THLT, 1, 6'd0, 0, 1, 1, 0, 1, 1'($urandom), 17'($urandom));
          return;
        end
        if (w[0]) begin
          add(C_T5, 1, 6'd0, 0, 1, 1, 0, 0, 1'($urandom), 17'($urandom));
          add(C_T6, 1, RRD | RWR, 0, 1, 1, 0, 0, 1'($urandom), 17'($urandom));
        end
      end
    end
  endtask

  // Play up to lim expected clocks, then discard anything left over.
  task automatic run_queue(input string name, input int lim);
    rec_t r;
    int   k;
    k = 0;
    while (exp_q.size() > 0 && k < lim) begin
      r = exp_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ({tstate, mcyc, ienb, ale, rd_, wr_, io_m, hlta} !==
          {r.t, r.m, r.ienb, r.ale, r.rdn, r.wrn, r.io, r.hl}) begin
        n_err++;
        $display("FAIL %s clk%0d: got t=%0d m=%0d ienb=%b ale/rd_/wr_/io_m/hlta=%b%b%b%b%b, want t=%0d m=%0d ienb=%b %b%b%b%b%b",
                 name, k, tstate, mcyc, ienb, ale, rd_, wr_, io_m, hlta,
                 r.t, r.m, r.ienb, r.ale, r.rdn, r.wrn, r.io, r.hl);
      end
      ready = r.rdy;
      chk_i = r.chk;
      k++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_  = 1'b0;
    ready = 1'($urandom);
    chk_i = 17'($urandom);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tstate, mcyc, ienb, ale, rd_, wr_, io_m, hlta} !== {3'd0, 3'd1, 6'd0, 5'b01100}) begin
      n_err++;
      $display("FAIL reset: got t=%0d m=%0d ienb=%b ale/rd_/wr_/io_m/hlta=%b%b%b%b%b, want t=0 m=1 ienb=0 01100",
               tstate, mcyc, ienb, ale, rd_, wr_, io_m, hlta);
    end
    rst_ = 1'b1;
  endtask

  task automatic test_mov();
    model_instr(mkw(4'h0, 4'h0, 4'h0, 0, 0, 0), 10'd0, 0);
    model_instr(mkw(4'h0, 4'h0, 4'h0, 0, 0, 0), 10'd0, 0);
    run_queue("mov_b_c", 1000);
  endtask

  task automatic test_mvi();
    model_instr(mkw(4'h1, 4'h0, 4'h0, 0, 0, 0), 10'd0, 0);
    run_queue("mvi_a", 1000);
  endtask

  task automatic test_mov_m();
    model_instr(mkw(4'h1, 4'h1, 4'h1, 0, 0, 0), 10'd0, 0);
    run_queue("mov_m_a", 1000);
  endtask

  task automatic test_wait();
    model_instr(mkw(4'h0, 4'h0, 4'h0, 0, 0, 0), 10'd2, 0);
    model_instr(mkw(4'h1, 4'h0, 4'h1, 0, 0, 0), 10'b0000000110, 0);
    run_queue("wait", 1000);
  endtask

  task automatic test_push();
    model_instr(mkw(4'h3, 4'h3, 4'h3, 1, 0, 0), 10'd0, 0);
    run_queue("push_b", 1000);
  endtask

  task automatic test_out();
    model_instr(mkw(4'h3, 4'h2, 4'h2, 0, 0, 1), 10'd0, 0);
    run_queue("out", 1000);
  endtask

  task automatic test_random();
    int n;
    logic [16:0] w;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 4);
      w = {1'($urandom), 4'($urandom), 4'($urandom), 4'((1 << n) - 1),
           1'($urandom), 1'b0, 1'($urandom), 1'($urandom)};
      model_instr(w, 10'($urandom), 0);
    end
    run_queue("random", 100000);
  endtask

  task automatic test_reset_abort();
    model_instr(mkw(4'hF, 4'h5, 4'h3, 1, 0, 1), 10'($urandom), 0);
    run_queue("abort_pre", 9);
    test_reset();
    model_instr(mkw(4'h0, 4'h0, 4'h0, 0, 0, 0), 10'd0, 0);
    run_queue("abort_post", 1000);
  endtask

  task automatic test_halt();
    model_instr(mkw(4'h0, 4'h0, 4'h0, 0, 1, 0), 10'd0, 10);
    run_queue("hlt", 1000);
    test_reset();
    model_instr(mkw(4'h0, 4'h0, 4'h0, 0, 0, 0), 10'd0, 0);
    run_queue("after_hlt", 1000);
  endtask

  initial begin
    test_reset();
    test_mov();
    test_mvi();
    test_mov_m();
    test_wait();
    test_push();
    test_out();
    test_random();
    test_reset_abort();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
